// File: rtl/apb_slave_regbank.sv
// APB completer register bank: ID word, saturating error counter and RW words,
// with a fixed number of pready wait states and pslverr on illegal accesses.
module apb_slave_regbank #(
    parameter int          NREGS       = 16,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);
    localparam int         IW = $clog2(NREGS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] regs [NREGS];
    logic [7:0]  errcnt;

    logic [31:0] widx;
    logic [IW-1:0] idx_l;
    logic        err, ready, commit, wr_en;
    logic [31:0] rd_word;
    logic        unused_addr;

    assign unused_addr = ^paddr[31:ADDR_W];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                // penable without a setup phase never starts a transfer
                if (psel && !penable) begin
                    cnt_nx   = WS;
                    state_nx = (WS == 4'd0) ? READY : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt == 4'd1) state_nx = READY;
                end
            end
            READY: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign widx   = 32'(paddr[ADDR_W-1:2]);
    assign idx_l  = paddr[IW+1:2];
    assign err    = (paddr[1:0] != 2'b00) || (widx >= 32'(NREGS)) || (pwrite && widx == 32'd0);
    assign ready  = (state == READY);
    assign commit = ready && psel && penable;
    assign wr_en  = commit && pwrite && !err && (widx >= 32'd2);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[idx_l] <= pwdata;
        end
    end

    // an ERRCNT write is never an errored transfer, so the two cannot collide
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            errcnt <= '0;
        end else if (commit) begin
            if (err) begin
                if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
            end else if (pwrite && widx == 32'd1) begin
                errcnt <= '0;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (widx == 32'd0)      rd_word = ID_VALUE;
        else if (widx == 32'd1) rd_word = {24'b0, errcnt};
        else                    rd_word = regs[idx_l];
    end

    assign pready  = ready;
    assign pslverr = ready && err;
    assign prdata  = (ready && !pwrite && !err) ? rd_word : '0;

endmodule
